// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared constants, state encoding and fault rule for the data memory LSU
//
// Purpose: funct3 size codes, FSM state encoding and the access-fault
// predicate used by data_mem_lsu.
// Contents: SZ_* size constants, lsu_state_e, access_fault().

package data_mem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } lsu_state_e;

   // aw is the byte-address width of the array; any address bit at or
   // above it points outside the array.
   function automatic logic access_fault(input logic        we,
                                         input logic [2:0]  size,
                                         input logic [31:0] addr,
                                         input int unsigned aw);
      logic bad_size;
      logic misalign;
      logic out_of_range;
      logic bad_store;
      bad_size     = (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
      misalign     = ((size == SZ_H || size == SZ_HU) && addr[0]) ||
                     ((size == SZ_W) && (addr[1:0] != 2'b00));
      out_of_range = ((addr >> aw) != 32'd0);
      // Stores have no unsigned variants, so any 1xx size is illegal.
      bad_store    = we && size[2];
      return bad_size || misalign || out_of_range || bad_store;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane merge for stores and lane select/extend for loads
//
// Purpose: purely combinational lane handling between the core data bus and
// a 32-bit memory word.
// Ports:
//   lane_i     byte offset within the word (addr[1:0])
//   size_i     funct3 access size
//   wdata_i    right-aligned store data
//   word_i     current contents of the addressed word
//   merged_o   word_i with the store bytes replaced
//   rdata_o    selected lane, sign- or zero-extended

module mem_lane_align
   import data_mem_pkg::*;
(
   input  logic [1:0]  lane_i,
   input  logic [2:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] word_i,
   output logic [31:0] merged_o,
   output logic [31:0] rdata_o
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [31:0] shifted;
   logic        is_byte;
   logic        is_half;

   assign byte_sh = {lane_i, 3'b000};
   // Halfword lanes are 0 or 2; lane_i[0] is never set for a legal halfword.
   assign half_sh = {lane_i[1], 4'b0000};
   assign is_byte = (size_i == SZ_B) || (size_i == SZ_BU);
   assign is_half = (size_i == SZ_H) || (size_i == SZ_HU);

   always_comb begin
      merged_o = word_i;
      if (is_byte) begin
         merged_o[byte_sh +: 8] = wdata_i[7:0];
      end else if (is_half) begin
         merged_o[half_sh +: 16] = wdata_i[15:0];
      end else begin
         merged_o = wdata_i;
      end
   end

   assign shifted = word_i >> byte_sh;

   always_comb begin
      rdata_o = word_i;
      if (is_byte) begin
         // size_i[2] marks the unsigned variants.
         rdata_o = {{24{shifted[7] & ~size_i[2]}}, shifted[7:0]};
      end else if (is_half) begin
         rdata_o = {{16{shifted[15] & ~size_i[2]}}, shifted[15:0]};
      end
   end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - handshaked byte/half/word data memory with wait states and fault reporting
//
// Purpose: accepts one load/store at a time from the core, waits LATENCY
// cycles, performs the array access and returns a one-cycle response.
// Parameters: DEPTH (32-bit words, power of two >= 4), LATENCY (0..15).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid_i/ready_o    request handshake (ready only while idle)
//   req_we_i, req_size_i   store flag, funct3 size
//   req_addr_i, req_wdata_i byte address, right-aligned store data
//   resp_valid_o           one-cycle response pulse
//   resp_rdata_o, resp_err_o extended load data (0 for stores/faults), fault flag

module data_mem_lsu
   import data_mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_size_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int AW = $clog2(DEPTH) + 2;
   localparam logic [1:0] ST_IDLE = 2'(S_IDLE);
   localparam logic [1:0] ST_WAIT = 2'(S_WAIT);
   localparam logic [1:0] ST_RESP = 2'(S_RESP);
   localparam logic [3:0] LAT4 = 4'(LATENCY);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q;
   logic [2:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;
   logic [31:0] mem_q [DEPTH];

   logic        access;
   logic        use_in;
   logic        acc_we;
   logic [2:0]  acc_size;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [AW-3:0] acc_idx;
   logic        acc_fault;
   logic [31:0] old_word;
   logic [31:0] merged_word;
   logic [31:0] load_data;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               cnt_d = LAT4;
               if (LATENCY == 0) begin
                  state_d = ST_RESP;
                  access  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
               access  = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // With zero wait states the access happens on the accept edge itself,
   // before the request latch holds anything, so take the live inputs.
   assign use_in    = (state_q == ST_IDLE);
   assign acc_we    = use_in ? req_we_i    : we_q;
   assign acc_size  = use_in ? req_size_i  : size_q;
   assign acc_addr  = use_in ? req_addr_i  : addr_q;
   assign acc_wdata = use_in ? req_wdata_i : wdata_q;
   assign acc_idx   = acc_addr[AW-1:2];
   assign acc_fault = access_fault(acc_we, acc_size, acc_addr, AW);
   assign old_word  = mem_q[acc_idx];

   mem_lane_align u_align (
      .lane_i   (acc_addr[1:0]),
      .size_i   (acc_size),
      .wdata_i  (acc_wdata),
      .word_i   (old_word),
      .merged_o (merged_word),
      .rdata_o  (load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         size_q       <= 3'b000;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == ST_IDLE && req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
         if (access) begin
            resp_err_q   <= acc_fault;
            resp_rdata_q <= (acc_fault || acc_we) ? 32'd0 : load_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else if (access && acc_we && !acc_fault) begin
         mem_q[acc_idx] <= merged_word;
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = (state_q == ST_RESP);
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu (LATENCY=2 and LATENCY=0 instances)

module tb_data_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;

   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        z_req_valid, z_req_ready, z_req_we;
   logic [2:0]  z_req_size;
   logic [31:0] z_req_addr, z_req_wdata;
   logic        z_resp_valid, z_resp_err;
   logic [31:0] z_resp_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [2][256];

   always #5 clk = ~clk;

   data_mem_lsu #(.DEPTH(256), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_size_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
   );

   data_mem_lsu #(.DEPTH(256), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_we_i(z_req_we),
      .req_size_i(z_req_size), .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata),
      .resp_valid_o(z_resp_valid), .resp_rdata_o(z_resp_rdata), .resp_err_o(z_resp_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < 256; i++) mdl[w][i] = 32'd0;
   endtask

   // Reference: byte-addressed memory semantics of RV32 loads/stores.
   task automatic model(input int w, input logic we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err);
      int nbytes;
      int idx;
      int sh;
      logic [31:0] word;
      logic [31:0] val;
      nbytes = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
      err = (sz == 3'd3) || (sz == 3'd6) || (sz == 3'd7) || (we && sz[2]) ||
            (a >= 32'd1024) || ((a % nbytes) != 0);
      rd = 32'd0;
      if (!err) begin
         idx  = int'(a / 4);
         sh   = int'(a % 4) * 8;
         word = mdl[w][idx];
         if (we) begin
            for (int k = 0; k < nbytes; k++) word[sh + 8*k +: 8] = wd[8*k +: 8];
            mdl[w][idx] = word;
         end else begin
            val = word >> sh;
            if (nbytes == 1)      rd = sz[2] ? 32'(val[7:0])  : 32'($signed(val[7:0]));
            else if (nbytes == 2) rd = sz[2] ? 32'(val[15:0]) : 32'($signed(val[15:0]));
            else                  rd = val;
         end
      end
   endtask

   task automatic gen(output logic we, output logic [2:0] sz, output logic [31:0] a, output logic [31:0] wd);
      logic [2:0] good [5];
      good[0] = 3'b000; good[1] = 3'b001; good[2] = 3'b010; good[3] = 3'b100; good[4] = 3'b101;
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 99) < 85) ? good[$urandom_range(0, 4)] : 3'($urandom);
      a  = ($urandom_range(0, 99) < 90) ? 32'($urandom_range(0, 63)) : (32'h400 + 32'($urandom_range(0, 15)));
      wd = $urandom;
   endtask

   // Called at a negedge with the LATENCY=2 instance idle; returns at a negedge.
   task automatic do_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold,
                         output logic [31:0] rd, output logic er);
      logic [31:0] erd;
      logic        eer;
      int n;
      bit got;
      model(0, we, sz, a, wd, erd, eer);
      check_eq("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
      @(posedge clk);
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (resp_valid) begin
            got = 1;
            req_valid = 1'b0;
         end else begin
            check_eq("ready_busy", 32'(req_ready), 32'd0);
            if (hold) begin
               req_we = 1'($urandom); req_size = 3'($urandom);
               req_addr = $urandom_range(0, 1023); req_wdata = $urandom;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      check_eq("resp_seen", 32'(got), 32'd1);
      check_eq("latency", 32'(n), 32'd3);
      check_eq("rdata", resp_rdata, erd);
      check_eq("err", 32'(resp_err), 32'(eer));
      rd = resp_rdata; er = resp_err;
      check_eq("ready_in_resp", 32'(req_ready), 32'd0);
      @(negedge clk);
      check_eq("ready_after", 32'(req_ready), 32'd1);
      check_eq("valid_after", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        t_we;
      logic [2:0]  t_sz;
      logic [31:0] t_a, t_wd;
      logic [31:0] p_rd;
      logic        p_er;
      bit          exp_ready;
      bit          acc_prev;

      rst = 1'b1;
      req_valid = 0; req_we = 0; req_size = 0; req_addr = 0; req_wdata = 0;
      z_req_valid = 0; z_req_we = 0; z_req_size = 0; z_req_addr = 0; z_req_wdata = 0;
      clear_model();
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 32'(req_ready), 32'd1);
      check_eq("rst_valid", 32'(resp_valid), 32'd0);
      check_eq("rst_rdata", resp_rdata, 32'd0);
      check_eq("rst_err", 32'(resp_err), 32'd0);
      check_eq("rst_ready0", 32'(z_req_ready), 32'd1);
      check_eq("rst_valid0", 32'(z_resp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
      check_eq("sw_rdata0", rd, 32'd0);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      check_eq("lw_dead", rd, 32'hDEADBEEF);
      check_eq("lw_err", 32'(er), 32'd0);
      do_req(1, 3'b000, 32'h11, 32'h0000007F, 0, rd, er);
      do_req(0, 3'b000, 32'h11, 32'h0, 0, rd, er);
      check_eq("lb_7f", rd, 32'h0000007F);
      do_req(0, 3'b100, 32'h13, 32'h0, 0, rd, er);
      check_eq("lbu_de", rd, 32'h000000DE);
      do_req(0, 3'b001, 32'h12, 32'h0, 0, rd, er);
      check_eq("lh_dead", rd, 32'hFFFFDEAD);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      check_eq("lw_merge", rd, 32'hDEAD7FEF);

      do_req(0, 3'b001, 32'h01, 32'h0, 0, rd, er);
      check_eq("lh_mis_err", 32'(er), 32'd1);
      do_req(1, 3'b010, 32'h22, 32'h55555555, 0, rd, er);
      check_eq("sw_mis_err", 32'(er), 32'd1);
      do_req(0, 3'b010, 32'h400, 32'h0, 0, rd, er);
      check_eq("oor_err", 32'(er), 32'd1);
      check_eq("oor_rdata", rd, 32'd0);
      do_req(0, 3'b011, 32'h10, 32'h0, 0, rd, er);
      check_eq("sz3_err", 32'(er), 32'd1);
      check_eq("sz3_rdata", rd, 32'd0);
      do_req(1, 3'b100, 32'h10, 32'hFFFFFFFF, 0, rd, er);
      check_eq("sbu_err", 32'(er), 32'd1);
      do_req(0, 3'b010, 32'h20, 32'h0, 0, rd, er);
      check_eq("lw20_zero", rd, 32'd0);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      check_eq("lw10_kept", rd, 32'hDEAD7FEF);

      do_req(1, 3'b010, 32'h30, 32'hA5A5A5A5, 1, rd, er);
      do_req(0, 3'b010, 32'h30, 32'h0, 1, rd, er);
      check_eq("hold_lw", rd, 32'hA5A5A5A5);

      for (int i = 0; i < 40; i++) begin
         gen(t_we, t_sz, t_a, t_wd);
         do_req(t_we, t_sz, t_a, t_wd, bit'($urandom_range(0, 1)), rd, er);
      end

      req_valid = 1'b1; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h8; req_wdata = 32'h1234;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_eq("rst_wait_ready", 32'(req_ready), 32'd1);
      check_eq("rst_wait_valid", 32'(resp_valid), 32'd0);
      clear_model();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_no_pulse", 32'(resp_valid), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_valid", 32'(resp_valid), 32'd0);
      do_req(0, 3'b010, 32'h8, 32'h0, 0, rd, er);
      check_eq("lw8_dropped", rd, 32'd0);
      do_req(0, 3'b010, 32'h10, 32'h0, 0, rd, er);
      check_eq("lw10_cleared", rd, 32'd0);

      exp_ready = 1;
      acc_prev  = 0;
      p_rd = 0; p_er = 0;
      for (int c = 0; c < 40; c++) begin
         check_eq("l0_ready", 32'(z_req_ready), 32'(exp_ready));
         check_eq("l0_valid", 32'(z_resp_valid), 32'(acc_prev));
         if (z_resp_valid && acc_prev) begin
            check_eq("l0_rdata", z_resp_rdata, p_rd);
            check_eq("l0_err", 32'(z_resp_err), 32'(p_er));
         end
         gen(t_we, t_sz, t_a, t_wd);
         z_req_valid = 1'b1; z_req_we = t_we; z_req_size = t_sz; z_req_addr = t_a; z_req_wdata = t_wd;
         if (z_req_ready) begin
            model(1, t_we, t_sz, t_a, t_wd, p_rd, p_er);
            acc_prev = 1;
         end else begin
            acc_prev = 0;
         end
         exp_ready = !exp_ready;
         @(negedge clk);
      end
      z_req_valid = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=%0d", 0, 1);
      $fatal(1, "timeout");
   end

endmodule
